// File: rtl/ascon_perm_core.sv
// ----------------------------------------------------------------------------
// ascon_perm_core
//
// Purpose:
//   Sequential Ascon permutation engine. Holds the 320-bit state (x0..x4)
//   and a round counter. It runs p^12, p^8 or p^6 by applying the
//   combinational round datapath `permutation` ROUNDS_PER_CYCLE times per
//   clock. Requests arrive on a valid/ready handshake and results leave on a
//   second valid/ready handshake.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   upstream offers a state plus round count
//   in_ready_o   core can accept (IDLE only)
//   rounds_i     requested rounds: 12, 8 or 6
//   x0_i..x4_i   input state words
//   out_valid_o  permuted state available (DONE)
//   out_ready_i  downstream takes the result
//   x0_o..x4_o   raw state register contents
//   busy_o       high while rounds are being applied (RUN)
//   err_o        one-cycle pulse after an illegal request is consumed
//
// `permutation` (below the top) is the combinational round datapath:
//   round_cnt_i  rounds still to go; selects the round constants
//   x0_i..x4_i   state before this clock's rounds
//   x0_o..x4_o   state after ROUNDS_PER_CYCLE rounds
// ----------------------------------------------------------------------------

module permutation #(
    parameter int ROUNDS_PER_CYCLE = 3
) (
    input  logic [3:0]  round_cnt_i,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o
);

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One Ascon round: constant addition, bitsliced 5-bit S-box, linear layer.
    function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                                 input logic [7:0]   c);
        logic [63:0] a0, a1, a2, a3, a4;
        logic [63:0] t0, t1, t2, t3, t4;
        a0 = s[319:256];
        a1 = s[255:192];
        a2 = s[191:128];
        a3 = s[127:64];
        a4 = s[63:0];
        a2 = a2 ^ {56'd0, c};
        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;
        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;
        a0 = a0 ^ rotr(a0, 19) ^ rotr(a0, 28);
        a1 = a1 ^ rotr(a1, 61) ^ rotr(a1, 39);
        a2 = a2 ^ rotr(a2, 1)  ^ rotr(a2, 6);
        a3 = a3 ^ rotr(a3, 10) ^ rotr(a3, 17);
        a4 = a4 ^ rotr(a4, 7)  ^ rotr(a4, 41);
        return {a0, a1, a2, a3, a4};
    endfunction

    logic [319:0] s_comb;
    logic [3:0]   rnd_idx;

    // Round index r = 12 - round_cnt + i, so p^12 starts at 0xF0,
    // p^8 at 0xB4 and p^6 at 0x96 (constant = {~r, r}).
    always_comb begin
        s_comb  = {x0_i, x1_i, x2_i, x3_i, x4_i};
        rnd_idx = '0;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            rnd_idx = 4'd12 - round_cnt_i + 4'(i);
            s_comb  = ascon_round(s_comb, {4'hF - rnd_idx, rnd_idx});
        end
    end

    assign x0_o = s_comb[319:256];
    assign x1_o = s_comb[255:192];
    assign x2_o = s_comb[191:128];
    assign x3_o = s_comb[127:64];
    assign x4_o = s_comb[63:0];

endmodule

module ascon_perm_core #(
    parameter int ROUNDS_PER_CYCLE = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  rounds_i,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [3:0] RPC = 4'(ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e         fsm_q;
    logic [319:0] x_q;
    logic [319:0] x_d;
    logic [3:0]   cnt_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic         err_q;

    // Only counts that land exactly on zero are accepted, so the counter
    // never wraps.
    function automatic logic rounds_legal(input logic [3:0] r);
        return ((r == 4'd6) || (r == 4'd8) || (r == 4'd12)) &&
               ((int'(r) % ROUNDS_PER_CYCLE) == 0);
    endfunction

    permutation #(
        .ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)
    ) u_perm (
        .round_cnt_i (cnt_q),
        .x0_i        (x_q[319:256]),
        .x1_i        (x_q[255:192]),
        .x2_i        (x_q[191:128]),
        .x3_i        (x_q[127:64]),
        .x4_i        (x_q[63:0]),
        .x0_o        (x_d[319:256]),
        .x1_o        (x_d[255:192]),
        .x2_o        (x_d[191:128]),
        .x3_o        (x_d[127:64]),
        .x4_o        (x_d[63:0])
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q       <= IDLE;
            x_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        if (rounds_legal(rounds_i)) begin
                            x_q        <= {x0_i, x1_i, x2_i, x3_i, x4_i};
                            cnt_q      <= rounds_i;
                            fsm_q      <= RUN;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            // Illegal request is consumed; state untouched.
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    x_q <= x_d;
                    if (cnt_q == RPC) begin
                        cnt_q       <= '0;
                        fsm_q       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - RPC;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign x0_o        = x_q[319:256];
    assign x1_o        = x_q[255:192];
    assign x2_o        = x_q[191:128];
    assign x3_o        = x_q[127:64];
    assign x4_o        = x_q[63:0];

endmodule
